// File: rtl/trace_capture_ctrl_pkg.sv
// trace_capture_ctrl_pkg: shared types and constants for the trace buffer write side
package trace_capture_ctrl_pkg;
   localparam int TRB_WIDTH = 32;
   localparam int TRB_DEPTH = 32;
   localparam int TRB_MAX_TRACES = 8;
   localparam int TRB_DELAY_BITS = 2;
   localparam int TRB_SEG_BITS = $clog2(TRB_MAX_TRACES);
   localparam int TRB_WADDR_BITS = $clog2(TRB_DEPTH);
   localparam int TRB_POS_BITS = $clog2(TRB_WIDTH);
   typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} capture_state_t;
   typedef struct packed {
      logic trg_mode;
      logic [TRB_SEG_BITS-1:0] trg_num_traces;
      logic [TRB_DELAY_BITS-1:0] trg_delay;
   } control_t;
   typedef struct packed {
      logic trg_event;
      logic [TRB_POS_BITS-1:0] event_pos;
      logic [TRB_WADDR_BITS-1:0] event_addr;
   } status_t;
   localparam control_t CONTROL_DEFAULT = '0;
   localparam status_t STATUS_DEFAULT = '0;
endpackage

// File: rtl/trace_capture_ctrl_if.sv
// trace_capture_ctrl_if: probe, control and BRAM write signals of the capture controller
interface trace_capture_ctrl_if
   import trace_capture_ctrl_pkg::*;
#(
   parameter int WIDTH = TRB_WIDTH,
   parameter int DEPTH = TRB_DEPTH,
   parameter int MAX_TRACES = TRB_MAX_TRACES
);
   control_t control_i;
   logic arm_i;
   logic stop_i;
   logic valid_i;
   logic [WIDTH-1:0] data_i;
   logic [WIDTH-1:0] trg_i;
   logic we_o;
   logic [$clog2(DEPTH)-1:0] waddr_o;
   logic [WIDTH-1:0] wdata_o;
   status_t status_o;
   logic [$clog2(MAX_TRACES)-1:0] seg_o;
   logic busy_o;
   logic done_o;
   modport master (
      output control_i, arm_i, stop_i, valid_i, data_i, trg_i,
      input we_o, waddr_o, wdata_o, status_o, seg_o, busy_o, done_o
   );
   modport slave (
      input control_i, arm_i, stop_i, valid_i, data_i, trg_i,
      output we_o, waddr_o, wdata_o, status_o, seg_o, busy_o, done_o
   );
endinterface

// File: rtl/trace_capture_ctrl_trg_prio_enc.sv
// trg_prio_enc: index of the lowest set bit of a trigger vector, with a hit flag
module trg_prio_enc #(
   parameter int WIDTH = 32,
   parameter int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input logic [WIDTH-1:0] vec,
   output logic [PW-1:0] pos,
   output logic hit
);
   assign hit = |vec;
   always_comb begin
      pos = '0;
      for (int i = WIDTH - 1; i >= 0; i--) pos = vec[i] ? PW'(i) : pos;
   end
endmodule

// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl: segmented pre/post-trigger write controller for the trace BRAM
module trace_capture_ctrl
   import trace_capture_ctrl_pkg::*;
#(
   parameter int WIDTH = TRB_WIDTH,
   parameter int DEPTH = TRB_DEPTH,
   parameter int MAX_TRACES = TRB_MAX_TRACES,
   parameter int DELAY_BITS = TRB_DELAY_BITS
) (
   input logic clk,
   input logic rst,
   trace_capture_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(MAX_TRACES);
   localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   capture_state_t state, state_n;
   control_t ctl, ctl_n;
   status_t status, status_n;
   logic [SW-1:0] seg, seg_n;
   logic [AW-1:0] offset, off_n, off_wrap, seg_base, addr;
   logic [AW:0] cnt, cnt_n, cnt_inc, seg_len, post_len;
   logic [TRB_SEG_BITS-1:0] n;
   logic [AW-1:0] waddr, waddr_n;
   logic [WIDTH-1:0] wdata, wdata_n;
   logic we, we_n, take, trig, last_seg, complete, hit;
   logic [PW-1:0] pos;
   trg_prio_enc #(.WIDTH(WIDTH), .PW(PW)) u_enc (.vec(bus.trg_i), .pos(pos), .hit(hit));
   // Requested trace count beyond MAX_TRACES saturates to the largest legal split
   assign n = (int'(ctl.trg_num_traces) > SW) ? TRB_SEG_BITS'(SW) : ctl.trg_num_traces;
   assign seg_len = (AW+1)'(DEPTH) >> n;
   assign post_len = (seg_len >> DELAY_BITS) * ((AW+1)'(ctl.trg_delay) + (AW+1)'(1));
   assign seg_base = AW'(seg_len * (AW+1)'(seg));
   assign addr = seg_base + offset;
   assign off_wrap = ((AW+1)'(offset) + (AW+1)'(1) == seg_len) ? '0 : offset + 1'b1;
   assign last_seg = (AW+1)'(seg) == ((AW+1)'(1) << n) - (AW+1)'(1);
   assign take = bus.valid_i && (state == ARMED || state == POST);
   assign trig = state == ARMED && hit;
   assign cnt_inc = trig ? (AW+1)'(1) : cnt + 1'b1;
   assign complete = (trig || state == POST) && cnt_inc == post_len;
   always_comb begin
      state_n = state;
      ctl_n = ctl;
      status_n = status;
      seg_n = seg;
      off_n = offset;
      cnt_n = cnt;
      we_n = 1'b0;
      waddr_n = waddr;
      wdata_n = wdata;
      if (bus.arm_i) begin
         state_n = ARMED;
         ctl_n = bus.control_i;
         status_n = STATUS_DEFAULT;
         seg_n = '0;
         off_n = '0;
         cnt_n = '0;
      end else if (bus.stop_i && state != IDLE) begin
         state_n = DONE;
      end else if (take) begin
         we_n = 1'b1;
         waddr_n = addr;
         wdata_n = bus.data_i;
         off_n = off_wrap;
         cnt_n = cnt_inc;
         state_n = trig ? POST : state;
         status_n = trig ? '{trg_event: 1'b1, event_pos: TRB_POS_BITS'(pos),
                             event_addr: TRB_WADDR_BITS'(addr)} : status;
         // Next segment starts on the very next valid sample; single mode parks on the last one
         if (complete) begin
            state_n = (last_seg && !ctl.trg_mode) ? DONE : ARMED;
            seg_n = !last_seg ? seg + 1'b1 : (ctl.trg_mode ? '0 : seg);
            off_n = '0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ctl <= CONTROL_DEFAULT;
         status <= STATUS_DEFAULT;
         seg <= '0;
         offset <= '0;
         cnt <= '0;
         we <= 1'b0;
         waddr <= '0;
         wdata <= '0;
      end else begin
         state <= state_n;
         ctl <= ctl_n;
         status <= status_n;
         seg <= seg_n;
         offset <= off_n;
         cnt <= cnt_n;
         we <= we_n;
         waddr <= waddr_n;
         wdata <= wdata_n;
      end
   end
   assign bus.we_o = we;
   assign bus.waddr_o = waddr;
   assign bus.wdata_o = wdata;
   assign bus.status_o = status;
   assign bus.seg_o = seg;
   assign bus.busy_o = state == ARMED || state == POST;
   assign bus.done_o = state == DONE;
endmodule

// File: tb/tb_trace_capture_ctrl.sv
// tb_trace_capture_ctrl: directed scenarios for the trace capture controller
module tb_trace_capture_ctrl;
   import trace_capture_ctrl_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int fails = 0;
   trace_capture_ctrl_if #(.WIDTH(32), .DEPTH(32), .MAX_TRACES(8)) bus ();
   trace_capture_ctrl #(.WIDTH(32), .DEPTH(32), .MAX_TRACES(8), .DELAY_BITS(2)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   always #5 clk = ~clk;

   task automatic step(input logic v, input logic [31:0] d, input logic [31:0] t);
      bus.valid_i = v;
      bus.data_i = d;
      bus.trg_i = t;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      bus.arm_i = 1'b0;
      bus.stop_i = 1'b0;
      bus.trg_i = '0;
   endtask

   task automatic arm(input logic mode, input logic [2:0] nt, input logic [1:0] dl);
      bus.control_i = '{trg_mode: mode, trg_num_traces: nt, trg_delay: dl};
      bus.arm_i = 1'b1;
      step(1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_reset();
      step(1'b0, 32'h0, 32'h0);
      checks++;
      if ({bus.we_o, bus.waddr_o, bus.wdata_o, bus.status_o, bus.seg_o, bus.busy_o, bus.done_o} !== '0) begin
         fails++;
         $display("FAIL reset we=%b waddr=%0d wdata=%h status=%h seg=%0d busy=%b done=%b exp all zero",
                  bus.we_o, bus.waddr_o, bus.wdata_o, bus.status_o, bus.seg_o, bus.busy_o, bus.done_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      status_t es;
      arm(1'b0, 3'd0, 2'd3);
      checks++;
      if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0 || bus.we_o !== 1'b0 || bus.status_o !== '0) begin
         fails++;
         $display("FAIL single_arm busy=%b done=%b we=%b status=%h exp 1 0 0 0",
                  bus.busy_o, bus.done_o, bus.we_o, bus.status_o);
      end
      for (int i = 0; i < 10; i++) begin
         if (i == 5) begin
            step(1'b0, 32'hdead, 32'h0);
            checks++;
            if (bus.we_o !== 1'b0) begin
               fails++;
               $display("FAIL single_gap we=%b exp 0", bus.we_o);
            end
         end
         step(1'b1, 32'(i), 32'h0);
         checks++;
         if (bus.we_o !== 1'b1 || bus.waddr_o !== 5'(i) || bus.wdata_o !== 32'(i)) begin
            fails++;
            $display("FAIL single_pre we=%b waddr=%0d wdata=%h exp 1 %0d %h", bus.we_o, bus.waddr_o, bus.wdata_o, i, i);
         end
      end
      step(1'b1, 32'hA, 32'h20);
      es = '{trg_event: 1'b1, event_pos: 5'd5, event_addr: 5'd10};
      checks++;
      if (bus.we_o !== 1'b1 || bus.waddr_o !== 5'd10 || bus.wdata_o !== 32'hA || bus.status_o !== es) begin
         fails++;
         $display("FAIL single_trig we=%b waddr=%0d wdata=%h status=%h exp 1 10 a %h",
                  bus.we_o, bus.waddr_o, bus.wdata_o, bus.status_o, es);
      end
      for (int k = 1; k <= 31; k++) begin
         if (k == 16) begin
            step(1'b0, 32'h0, 32'h0);
            checks++;
            if (bus.we_o !== 1'b0 || bus.busy_o !== 1'b1) begin
               fails++;
               $display("FAIL single_post_gap we=%b busy=%b exp 0 1", bus.we_o, bus.busy_o);
            end
         end
         step(1'b1, 32'(100 + k), (k == 3) ? 32'h1 : 32'h0);
         checks++;
         if (bus.we_o !== 1'b1 || bus.waddr_o !== 5'((10 + k) % 32) || bus.done_o !== (k == 31)
             || bus.busy_o !== (k != 31) || bus.status_o !== es) begin
            fails++;
            $display("FAIL single_post k=%0d we=%b waddr=%0d done=%b busy=%b status=%h exp 1 %0d %b %b %h",
                     k, bus.we_o, bus.waddr_o, bus.done_o, bus.busy_o, bus.status_o,
                     (10 + k) % 32, k == 31, k != 31, es);
         end
      end
      step(1'b1, 32'h55, 32'h1);
      checks++;
      if (bus.we_o !== 1'b0 || bus.done_o !== 1'b1 || bus.status_o !== es) begin
         fails++;
         $display("FAIL single_done_hold we=%b done=%b status=%h exp 0 1 %h", bus.we_o, bus.done_o, bus.status_o, es);
      end
   endtask

   task automatic test_min_post();
      arm(1'b0, 3'd0, 2'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 32'(i), 32'h0);
      step(1'b1, 32'h3, 32'h4);
      checks++;
      if (bus.status_o.event_addr !== 5'd3 || bus.status_o.event_pos !== 5'd2 || bus.waddr_o !== 5'd3) begin
         fails++;
         $display("FAIL minpost_trig event_addr=%0d event_pos=%0d waddr=%0d exp 3 2 3",
                  bus.status_o.event_addr, bus.status_o.event_pos, bus.waddr_o);
      end
      for (int k = 1; k <= 7; k++) begin
         step(1'b1, 32'(k), 32'h0);
         checks++;
         if (bus.we_o !== 1'b1 || bus.waddr_o !== 5'(3 + k) || bus.done_o !== (k == 7)) begin
            fails++;
            $display("FAIL minpost_post k=%0d we=%b waddr=%0d done=%b exp 1 %0d %b",
                     k, bus.we_o, bus.waddr_o, bus.done_o, 3 + k, k == 7);
         end
      end
      step(1'b1, 32'h9, 32'h0);
      checks++;
      if (bus.we_o !== 1'b0 || bus.done_o !== 1'b1) begin
         fails++;
         $display("FAIL minpost_stop we=%b done=%b exp 0 1", bus.we_o, bus.done_o);
      end
   endtask

   task automatic test_segments(input logic mode);
      arm(mode, 3'd2, 2'd1);
      for (int s = 0; s < 4; s++) begin
         for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'(s * 16 + i), (i == 2) ? (32'h1 << (s + 1)) : 32'h0);
            checks++;
            if (bus.we_o !== 1'b1 || bus.waddr_o !== 5'(s * 8 + i) || bus.wdata_o !== 32'(s * 16 + i)) begin
               fails++;
               $display("FAIL seg_write mode=%b s=%0d i=%0d we=%b waddr=%0d wdata=%h exp 1 %0d %h",
                        mode, s, i, bus.we_o, bus.waddr_o, bus.wdata_o, s * 8 + i, s * 16 + i);
            end
            if (i == 2) begin
               checks++;
               if (bus.status_o.trg_event !== 1'b1 || bus.status_o.event_pos !== 5'(s + 1)
                   || bus.status_o.event_addr !== 5'(s * 8 + 2) || bus.seg_o !== 3'(s)) begin
                  fails++;
                  $display("FAIL seg_status mode=%b s=%0d status=%h seg=%0d exp pos %0d addr %0d seg %0d",
                           mode, s, bus.status_o, bus.seg_o, s + 1, s * 8 + 2, s);
               end
            end
         end
         checks++;
         if (s < 3 && (bus.seg_o !== 3'(s + 1) || bus.busy_o !== 1'b1 || bus.done_o !== 1'b0)) begin
            fails++;
            $display("FAIL seg_step mode=%b s=%0d seg=%0d busy=%b done=%b exp %0d 1 0",
                     mode, s, bus.seg_o, bus.busy_o, bus.done_o, s + 1);
         end else if (s == 3 && !mode && (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.seg_o !== 3'd3)) begin
            fails++;
            $display("FAIL seg_done done=%b busy=%b seg=%0d exp 1 0 3", bus.done_o, bus.busy_o, bus.seg_o);
         end else if (s == 3 && mode && (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.seg_o !== 3'd0)) begin
            fails++;
            $display("FAIL seg_wrap done=%b busy=%b seg=%0d exp 0 1 0", bus.done_o, bus.busy_o, bus.seg_o);
         end
      end
      if (mode) begin
         step(1'b1, 32'h70, 32'h0);
         step(1'b1, 32'h71, 32'h300);
         checks++;
         if (bus.waddr_o !== 5'd1 || bus.status_o.event_pos !== 5'd8 || bus.status_o.event_addr !== 5'd1) begin
            fails++;
            $display("FAIL cont_overwrite waddr=%0d event_pos=%0d event_addr=%0d exp 1 8 1",
                     bus.waddr_o, bus.status_o.event_pos, bus.status_o.event_addr);
         end
      end
   endtask

   task automatic test_priority();
      arm(1'b0, 3'd0, 2'd0);
      step(1'b1, 32'h1, 32'h80000010);
      checks++;
      if (bus.status_o.event_pos !== 5'd4 || bus.status_o.event_addr !== 5'd0 || bus.busy_o !== 1'b1) begin
         fails++;
         $display("FAIL prio_enc event_pos=%0d event_addr=%0d busy=%b exp 4 0 1",
                  bus.status_o.event_pos, bus.status_o.event_addr, bus.busy_o);
      end
      bus.stop_i = 1'b1;
      step(1'b1, 32'h2, 32'h0);
      checks++;
      if (bus.we_o !== 1'b0 || bus.done_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.status_o.event_pos !== 5'd4) begin
         fails++;
         $display("FAIL prio_stop we=%b done=%b busy=%b event_pos=%0d exp 0 1 0 4",
                  bus.we_o, bus.done_o, bus.busy_o, bus.status_o.event_pos);
      end
      bus.arm_i = 1'b1;
      bus.stop_i = 1'b1;
      step(1'b1, 32'h5, 32'h1);
      checks++;
      if (bus.we_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.done_o !== 1'b0 || bus.status_o.trg_event !== 1'b0) begin
         fails++;
         $display("FAIL prio_arm we=%b busy=%b done=%b trg_event=%b exp 0 1 0 0",
                  bus.we_o, bus.busy_o, bus.done_o, bus.status_o.trg_event);
      end
      step(1'b1, 32'h6, 32'h0);
      checks++;
      if (bus.we_o !== 1'b1 || bus.waddr_o !== 5'd0 || bus.status_o.trg_event !== 1'b0) begin
         fails++;
         $display("FAIL prio_rearm we=%b waddr=%0d trg_event=%b exp 1 0 0", bus.we_o, bus.waddr_o, bus.status_o.trg_event);
      end
   endtask

   task automatic test_reset_mid_post();
      arm(1'b0, 3'd2, 2'd1);
      step(1'b1, 32'h0, 32'h1);
      for (int i = 1; i < 4; i++) step(1'b1, 32'(i), 32'h0);
      step(1'b1, 32'h8, 32'h2);
      checks++;
      if (bus.seg_o !== 3'd1 || bus.waddr_o !== 5'd8 || bus.busy_o !== 1'b1) begin
         fails++;
         $display("FAIL rst_setup seg=%0d waddr=%0d busy=%b exp 1 8 1", bus.seg_o, bus.waddr_o, bus.busy_o);
      end
      rst = 1'b1;
      step(1'b1, 32'h9, 32'h0);
      rst = 1'b0;
      checks++;
      if (bus.we_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.status_o !== '0 || bus.seg_o !== 3'd0) begin
         fails++;
         $display("FAIL rst_mid we=%b busy=%b done=%b status=%h seg=%0d exp 0 0 0 0 0",
                  bus.we_o, bus.busy_o, bus.done_o, bus.status_o, bus.seg_o);
      end
      arm(1'b0, 3'd0, 2'd0);
      step(1'b1, 32'h7, 32'h4);
      checks++;
      if (bus.we_o !== 1'b1 || bus.waddr_o !== 5'd0 || bus.status_o !== status_t'({1'b1, 5'd2, 5'd0})) begin
         fails++;
         $display("FAIL rst_rearm we=%b waddr=%0d status=%h exp 1 0 %h", bus.we_o, bus.waddr_o, bus.status_o,
                  status_t'({1'b1, 5'd2, 5'd0}));
      end
   endtask

   initial begin
      bus.control_i = CONTROL_DEFAULT;
      bus.arm_i = 1'b0;
      bus.stop_i = 1'b0;
      bus.valid_i = 1'b0;
      bus.data_i = '0;
      bus.trg_i = '0;
      test_reset();
      test_single();
      test_min_post();
      test_segments(1'b0);
      test_segments(1'b1);
      test_priority();
      test_reset_mid_post();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
